// File: rtl/recovery_rf_restore.sv
// Recovery register file restore sequencer.
// Sweeps the recovery RF two entries per cycle (even entry on port A, odd entry
// on port B) and replays each pair into the core RF write ports through a
// single-entry output stage with a valid/ready handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start_i, read addresses parked at 0
// S_RUN    | reading pair ptr_q, loading the output stage whenever it frees up
// S_DRAIN  | all pairs read, waiting for the core to accept the last pair
// S_DONE   | one-cycle completion pulse on done_o
module recovery_rf_restore #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned NumRegs    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_a_o,
  input  logic [DataWidth-1:0]  rf_rdata_a_i,
  output logic [ADDR_WIDTH-1:0] rf_raddr_b_o,
  input  logic [DataWidth-1:0]  rf_rdata_b_i,
  input  logic                  core_ready_i,
  output logic                  core_we_a_o,
  output logic [ADDR_WIDTH-1:0] core_waddr_a_o,
  output logic [DataWidth-1:0]  core_wdata_a_o,
  output logic                  core_we_b_o,
  output logic [ADDR_WIDTH-1:0] core_waddr_b_o,
  output logic [DataWidth-1:0]  core_wdata_b_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int unsigned PtrWidth = ADDR_WIDTH - 1;
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(NumRegs / 2 - 1);

  logic [1:0]            state_q;
  logic [PtrWidth-1:0]   ptr_q;
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] waddr_a_q;
  logic [ADDR_WIDTH-1:0] waddr_b_q;
  logic [DataWidth-1:0]  wdata_a_q;
  logic [DataWidth-1:0]  wdata_b_q;
  logic                  in_run;
  logic                  advance;
  logic [ADDR_WIDTH-1:0] raddr_a;
  logic [ADDR_WIDTH-1:0] raddr_b;

  // Output stage can take a new pair when it is empty or being drained now.
  always_comb begin
    in_run  = (state_q == S_RUN);
    advance = in_run & (~valid_q | core_ready_i);
    raddr_a = in_run ? {ptr_q, 1'b0} : '0;
    raddr_b = in_run ? {ptr_q, 1'b1} : '0;
  end

  // Sequencer state, pair pointer and output stage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      waddr_a_q <= '0;
      waddr_b_q <= '0;
      wdata_a_q <= '0;
      wdata_b_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_RUN;
            ptr_q   <= '0;
          end
        end
        S_RUN: begin
          if (advance) begin
            waddr_a_q <= raddr_a;
            waddr_b_q <= raddr_b;
            wdata_a_q <= rf_rdata_a_i;
            wdata_b_q <= rf_rdata_b_i;
            valid_q   <= 1'b1;
            ptr_q     <= ptr_q + PtrWidth'(1);
            if (ptr_q == LastPtr) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (valid_q && core_ready_i) begin
            valid_q <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status and write-port outputs; R0 is hardwired in the core, never write it.
  always_comb begin
    busy_o         = (state_q != S_IDLE);
    done_o         = (state_q == S_DONE);
    rf_raddr_a_o   = raddr_a;
    rf_raddr_b_o   = raddr_b;
    core_we_a_o    = valid_q & (waddr_a_q != '0);
    core_waddr_a_o = waddr_a_q;
    core_wdata_a_o = wdata_a_q;
    core_we_b_o    = valid_q;
    core_waddr_b_o = waddr_b_q;
    core_wdata_b_o = wdata_b_q;
  end

endmodule

// File: tb/tb_recovery_rf_restore.sv
// Directed bench for recovery_rf_restore: a 32-entry instance exercises the
// nominal sweep, backpressure, ignored restart, mid-sweep reset and drain
// stall; a 64-entry instance covers the integer+FP configuration.
module tb_recovery_rf_restore;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // 32-entry instance
  logic        start, ready, busy, done, we_a, we_b;
  logic [4:0]  raddr_a, raddr_b, waddr_a, waddr_b;
  logic [31:0] rdata_a, rdata_b, wdata_a, wdata_b;

  assign rdata_a = 32'hA500_0000 + 32'(raddr_a);
  assign rdata_b = 32'hA500_0000 + 32'(raddr_b);

  recovery_rf_restore #(.ADDR_WIDTH(5), .DataWidth(32), .NumRegs(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .rf_raddr_a_o(raddr_a), .rf_rdata_a_i(rdata_a),
    .rf_raddr_b_o(raddr_b), .rf_rdata_b_i(rdata_b),
    .core_ready_i(ready),
    .core_we_a_o(we_a), .core_waddr_a_o(waddr_a), .core_wdata_a_o(wdata_a),
    .core_we_b_o(we_b), .core_waddr_b_o(waddr_b), .core_wdata_b_o(wdata_b)
  );

  // 64-entry instance (integer + FP register file)
  logic        start1, ready1, busy1, done1, we_a1, we_b1;
  logic [5:0]  raddr_a1, raddr_b1, waddr_a1, waddr_b1;
  logic [31:0] rdata_a1, rdata_b1, wdata_a1, wdata_b1;

  assign rdata_a1 = 32'hA500_0000 + 32'(raddr_a1);
  assign rdata_b1 = 32'hA500_0000 + 32'(raddr_b1);

  recovery_rf_restore #(.ADDR_WIDTH(6), .DataWidth(32), .NumRegs(64)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .rf_raddr_a_o(raddr_a1), .rf_rdata_a_i(rdata_a1),
    .rf_raddr_b_o(raddr_b1), .rf_rdata_b_i(rdata_b1),
    .core_ready_i(ready1),
    .core_we_a_o(we_a1), .core_waddr_a_o(waddr_a1), .core_wdata_a_o(wdata_a1),
    .core_we_b_o(we_b1), .core_waddr_b_o(waddr_b1), .core_wdata_b_o(wdata_b1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One restore on the 32-entry instance. Cycle 0 carries the start pulse.
  // core_ready_i is low for cycles st_lo..st_hi; restart_c pulses start_i
  // again; rst_c asserts reset for one cycle and ends the sweep after the
  // post-reset check.
  task automatic sweep(input string tag, input int st_lo, input int st_hi,
                       input int restart_c, input int rst_c);
    int nstall, last, k, transfers, dones, exp_ra;
    logic exp_valid, in_run;
    nstall    = (st_hi >= st_lo) ? (st_hi - st_lo + 1) : 0;
    last      = 17 + nstall;
    k         = 0;
    transfers = 0;
    dones     = 0;
    for (int c = 0; c <= last + 2; c++) begin
      start = (c == 0) || (c == restart_c);
      ready = !(c >= st_lo && c <= st_hi);
      rst_n = (c != rst_c);
      @(negedge clk);
      if (rst_c >= 0 && c == rst_c + 1) begin
        chk({tag, " rst busy"}, 64'(busy), 64'd0);
        chk({tag, " rst done"}, 64'(done), 64'd0);
        chk({tag, " rst we_a"}, 64'(we_a), 64'd0);
        chk({tag, " rst we_b"}, 64'(we_b), 64'd0);
        chk({tag, " rst waddr_b"}, 64'(waddr_b), 64'd0);
        chk({tag, " rst wdata_a"}, 64'(wdata_a), 64'd0);
        chk({tag, " rst raddr_b"}, 64'(raddr_b), 64'd0);
        start = 1'b0;
        next_cycle();
        return;
      end
      exp_valid = (c >= 2) && (c <= last);
      in_run    = (c == 1) || (exp_valid && k < 15);
      exp_ra    = (c == 1) ? 0 : (in_run ? 2 * (k + 1) : 0);
      chk({tag, " busy"}, 64'(busy), 64'((c >= 1) && (c <= last + 1)));
      chk({tag, " done"}, 64'(done), 64'(c == last + 1));
      chk({tag, " we_b"}, 64'(we_b), 64'(exp_valid));
      chk({tag, " raddr_a"}, 64'(raddr_a), 64'(exp_ra));
      chk({tag, " raddr_b"}, 64'(raddr_b), in_run ? 64'(exp_ra + 1) : 64'd0);
      if (exp_valid) begin
        chk({tag, " waddr_a"}, 64'(waddr_a), 64'(2 * k));
        chk({tag, " waddr_b"}, 64'(waddr_b), 64'(2 * k + 1));
        chk({tag, " wdata_a"}, 64'(wdata_a), 64'(32'hA500_0000 + 32'(2 * k)));
        chk({tag, " wdata_b"}, 64'(wdata_b), 64'(32'hA500_0000 + 32'(2 * k + 1)));
        chk({tag, " we_a"}, 64'(we_a), 64'(k != 0));
        if (ready) k++;
      end else begin
        chk({tag, " we_a idle"}, 64'(we_a), 64'd0);
      end
      if (we_b && ready) transfers++;
      if (done) dones++;
      next_cycle();
    end
    start = 1'b0;
    ready = 1'b1;
    chk({tag, " transfers"}, 64'(transfers), 64'd16);
    chk({tag, " done pulses"}, 64'(dones), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int transfers, dones;
    rst_n  = 1'b0;
    start  = 1'b0;
    ready  = 1'b1;
    start1 = 1'b0;
    ready1 = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset we_a", 64'(we_a), 64'd0);
    chk("reset we_b", 64'(we_b), 64'd0);
    chk("reset waddr_a", 64'(waddr_a), 64'd0);
    chk("reset wdata_b", 64'(wdata_b), 64'd0);
    chk("reset raddr_a", 64'(raddr_a), 64'd0);
    chk("reset busy64", 64'(busy1), 64'd0);
    rst_n = 1'b1;
    next_cycle();
    next_cycle();

    sweep("nominal", 1, 0, -1, -1);
    sweep("stall", 4, 7, -1, -1);
    sweep("restart", 1, 0, 5, -1);
    sweep("midrst", 1, 0, -1, 8);
    next_cycle();
    sweep("after_rst", 1, 0, -1, -1);
    sweep("drain", 17, 19, -1, -1);

    // 64-entry sweep, core always ready
    transfers = 0;
    dones     = 0;
    for (int c = 0; c <= 36; c++) begin
      start1 = (c == 0);
      @(negedge clk);
      chk("fp busy", 64'(busy1), 64'((c >= 1) && (c <= 34)));
      chk("fp done", 64'(done1), 64'(c == 34));
      chk("fp we_b", 64'(we_b1), 64'((c >= 2) && (c <= 33)));
      if (c >= 2 && c <= 33) begin
        chk("fp waddr_a", 64'(waddr_a1), 64'(2 * (c - 2)));
        chk("fp waddr_b", 64'(waddr_b1), 64'(2 * (c - 2) + 1));
        chk("fp wdata_b", 64'(wdata_b1), 64'(32'hA500_0000 + 32'(2 * (c - 2) + 1)));
        chk("fp we_a", 64'(we_a1), 64'(c != 2));
        transfers++;
      end
      if (done1) dones++;
      next_cycle();
    end
    start1 = 1'b0;
    chk("fp transfers", 64'(transfers), 64'd32);
    chk("fp done pulses", 64'(dones), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
